// File: rtl/w0rm_periph_arbiter.sv
// Round-robin arbiter that shares the W0RM peripheral bus between the CPU data port (M0) and a secondary master (M1).
// Optional WAIT-state timeout is compiled in with the W0RM_PERIPH_TIMEOUT_EN macro.
module w0rm_periph_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  m0_valid,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_in,
  input  logic                  m1_valid,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_in,
  output logic                  m0_busy,
  output logic                  m1_busy,
  output logic                  m0_valid_out,
  output logic                  m1_valid_out,
  output logic [DATA_WIDTH-1:0] m0_data_out,
  output logic [DATA_WIDTH-1:0] m1_data_out,
  output logic                  p_valid,
  output logic                  p_read,
  output logic                  p_write,
  output logic [ADDR_WIDTH-1:0] p_addr,
  output logic [DATA_WIDTH-1:0] p_data_out,
  input  logic                  p_valid_in,
  input  logic [DATA_WIDTH-1:0] p_data_in,
  output logic                  timeout_error,
  output logic [1:0]            dbg_state_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [1:0]            pend_q;
  logic [1:0]            pend_clr;
  logic [1:0]            req_ok;
  logic [ADDR_WIDTH-1:0] slot_addr_q [2];
  logic [DATA_WIDTH-1:0] slot_data_q [2];
  logic [1:0]            slot_read_q, slot_write_q;
  logic                  load_p, cap, cap_to, expire;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [ADDR_WIDTH-1:0] p_addr_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  p_read_q, p_write_q;
  logic [DATA_WIDTH-1:0] m0_data_q, m1_data_q;

  // A strobe is taken only when the slot is free and exactly one of read/write is set.
  assign req_ok[0] = m0_valid & ~pend_q[0] & (m0_read ^ m0_write);
  assign req_ok[1] = m1_valid & ~pend_q[1] & (m1_read ^ m1_write);

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      pend_q       <= 2'b00;
      slot_read_q  <= 2'b00;
      slot_write_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      pend_q <= (pend_q & ~pend_clr) | req_ok;
      if (req_ok[0]) begin
        slot_addr_q[0]  <= m0_addr;
        slot_data_q[0]  <= m0_data_in;
        slot_read_q[0]  <= m0_read;
        slot_write_q[0] <= m0_write;
      end
      if (req_ok[1]) begin
        slot_addr_q[1]  <= m1_addr;
        slot_data_q[1]  <= m1_data_in;
        slot_read_q[1]  <= m1_read;
        slot_write_q[1] <= m1_write;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    pend_clr = 2'b00;
    load_p   = 1'b0;
    cap      = 1'b0;
    cap_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          // On a tie the master that was not served last wins.
          grant_d = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          load_p  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (p_valid_in) begin
          cap     = 1'b1;
          state_d = S_RESP;
        end else if (expire) begin
          cap     = 1'b1;
          cap_to  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        pend_clr[grant_q] = 1'b1;
        last_d            = grant_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cap_data = cap_to ? '0 : p_data_in;

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      p_addr_q  <= '0;
      p_data_q  <= '0;
      p_read_q  <= 1'b0;
      p_write_q <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (load_p) begin
        p_addr_q  <= slot_addr_q[grant_d];
        p_data_q  <= slot_data_q[grant_d];
        p_read_q  <= slot_read_q[grant_d];
        p_write_q <= slot_write_q[grant_d];
      end else if (state_q == S_RESP) begin
        p_read_q  <= 1'b0;
        p_write_q <= 1'b0;
      end
      if (cap) begin
        if (grant_q) m1_data_q <= cap_data;
        else         m0_data_q <= cap_data;
      end
    end
  end

`ifdef W0RM_PERIPH_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        to_q;

  assign expire = (state_q == S_WAIT) && (tcnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      tcnt_q <= 16'd0;
      to_q   <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)     tcnt_q <= 16'd0;
      else if (state_q == S_WAIT) tcnt_q <= tcnt_q + 16'd1;
      if (cap) to_q <= cap_to;
    end
  end

  assign timeout_error = (state_q == S_RESP) & to_q;
`else
  assign expire        = 1'b0;
  assign timeout_error = 1'b0;
`endif

  assign m0_busy      = pend_q[0];
  assign m1_busy      = pend_q[1];
  assign m0_valid_out = (state_q == S_RESP) & ~grant_q;
  assign m1_valid_out = (state_q == S_RESP) & grant_q;
  assign m0_data_out  = m0_data_q;
  assign m1_data_out  = m1_data_q;
  assign p_valid      = (state_q == S_ISSUE);
  assign p_read       = p_read_q;
  assign p_write      = p_write_q;
  assign p_addr       = p_addr_q;
  assign p_data_out   = p_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_w0rm_periph_arbiter.sv
// Scoreboard bench for w0rm_periph_arbiter: behavioural peripheral plus expected-access and expected-response queues.
// Handshake: mX_valid is a one-cycle strobe taken only while mX_busy is low; p_valid is answered by one p_valid_in pulse.
module tb_w0rm_periph_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          mem_clk = 1'b0;
  logic          cpu_reset = 1'b1;
  logic          m0_valid = 1'b0, m0_read = 1'b0, m0_write = 1'b0;
  logic          m1_valid = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_data_in = '0, m1_data_in = '0;
  logic          m0_busy, m1_busy, m0_valid_out, m1_valid_out;
  logic [DW-1:0] m0_data_out, m1_data_out;
  logic          p_valid, p_read, p_write;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data_out;
  logic          p_valid_in = 1'b0;
  logic [DW-1:0] p_data_in = '0;
  logic          timeout_error;
  logic [1:0]    dbg_state;

  w0rm_periph_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .m0_valid(m0_valid), .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_data_in(m0_data_in),
    .m1_valid(m1_valid), .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_data_in(m1_data_in),
    .m0_busy(m0_busy), .m1_busy(m1_busy), .m0_valid_out(m0_valid_out), .m1_valid_out(m1_valid_out),
    .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
    .p_valid(p_valid), .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_data_out(p_data_out),
    .p_valid_in(p_valid_in), .p_data_in(p_data_in), .timeout_error(timeout_error), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 mem_clk = ~mem_clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [65:0] exp_p_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int          grant_log[$];

  bit          periph_en  = 1'b1;
  int          resp_delay = 2;
  bit          inject     = 1'b0;
  bit          expect_to  = 1'b0;
  int          resp_wait  = 0;
  logic [31:0] resp_data  = '0;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] periph_resp(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a * 32'd3 + 32'h1234_0001);
  endfunction

  // Behavioural peripheral and scoreboard, both working on the falling edge.
  always @(negedge mem_clk) begin
    p_valid_in = 1'b0;
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        p_valid_in = 1'b1;
        p_data_in  = resp_data;
      end
    end
    if (inject) begin
      p_valid_in = 1'b1;
      p_data_in  = 32'hBAD0_BAD0;
      inject     = 1'b0;
    end
    if (p_valid === 1'b1) begin
      if (exp_p_q.size() == 0) check("p_unexpected", {p_read, p_write, p_addr, p_data_out}, 96'h0);
      else check("p_access", {p_read, p_write, p_addr, p_data_out}, exp_p_q.pop_front());
      if (periph_en) begin
        resp_wait = resp_delay;
        resp_data = periph_resp(p_addr);
      end
    end
    if (m0_valid_out === 1'b1) begin
      grant_log.push_back(0);
      if (exp0_q.size() == 0) check("m0_unexpected", 1, 0);
      else check("m0_data", m0_data_out, exp0_q.pop_front());
      check("m0_tmo", timeout_error, expect_to);
    end
    if (m1_valid_out === 1'b1) begin
      grant_log.push_back(1);
      if (exp1_q.size() == 0) check("m1_unexpected", 1, 0);
      else check("m1_data", m1_data_out, exp1_q.pop_front());
      check("m1_tmo", timeout_error, expect_to);
    end
    if (timeout_error === 1'b1 && m0_valid_out !== 1'b1 && m1_valid_out !== 1'b1)
      check("tmo_stray", 1, 0);
  end

  // driver tasks
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_valid = 1'b1; m0_read = rd; m0_write = wr; m0_addr = a; m0_data_in = d;
    end else begin
      m1_valid = 1'b1; m1_read = rd; m1_write = wr; m1_addr = a; m1_data_in = d;
    end
  endtask

  task automatic expect_req(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_p_q.push_back({rd, wr, a, d});
    if (periph_en) begin
      if (m == 0) exp0_q.push_back(periph_resp(a));
      else        exp1_q.push_back(periph_resp(a));
    end
  endtask

  task automatic clr_req();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  task automatic send(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input bit accept);
    set_req(m, rd, wr, a, d);
    if (accept) expect_req(m, rd, wr, a, d);
    tick();
    clr_req();
  endtask

  task automatic wait_free(input int m);
    int n = 0;
    while (((m == 0) ? m0_busy : m1_busy) !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) check("busy_stuck", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_p_q.size() != 0 || exp0_q.size() != 0 || exp1_q.size() != 0 || m0_busy || m1_busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_p", exp_p_q.size(), 0);
    check("drain_m0", exp0_q.size(), 0);
    check("drain_m1", exp1_q.size(), 0);
  endtask

  task automatic do_reset();
    clr_req();
    cpu_reset = 1'b1;
    #1;
    check("reset_outs", {m0_busy, m1_busy, m0_valid_out, m1_valid_out, p_valid, p_read, p_write, timeout_error},
          8'h00);
    check("reset_data", {p_addr, p_data_out, m0_data_out}, 96'h0);
    check("reset_m1_data", m1_data_out, 0);
    tick();
    tick();
    cpu_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    // Test 1: single M0 read, cycle-accurate latency and busy window
    do_reset();
    resp_delay = 2;
    send(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge mem_clk);
      check($sformatf("t1_busy_c%0d", c), m0_busy, (c <= 5));
      check($sformatf("t1_pvalid_c%0d", c), p_valid, (c == 2));
      check($sformatf("t1_vout_c%0d", c), m0_valid_out, (c == 5));
      if (c == 6) check("t1_pread_idle", p_read, 0);
      tick();
    end

    // Round-robin tie right after an M0 grant: M1 must go first
    resp_delay = $urandom_range(1, 4);
    set_req(0, 1'b0, 1'b1, 32'h80, 32'h55);
    set_req(1, 1'b0, 1'b1, 32'h84, 32'h66);
    expect_req(1, 1'b0, 1'b1, 32'h84, 32'h66);
    expect_req(0, 1'b0, 1'b1, 32'h80, 32'h55);
    tick();
    clr_req();
    drain();

    // Test 2: after reset both strobe together, M0 first
    do_reset();
    set_req(0, 1'b0, 1'b1, 32'h20, 32'h11);
    set_req(1, 1'b0, 1'b1, 32'h24, 32'h22);
    expect_req(0, 1'b0, 1'b1, 32'h20, 32'h11);
    expect_req(1, 1'b0, 1'b1, 32'h24, 32'h22);
    tick();
    clr_req();
    drain();

    // Test 3: continuous re-requests alternate M0, M1, M0, M1
    grant_log.delete();
    resp_delay = $urandom_range(1, 4);
    a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
    set_req(0, 1'b1, 1'b0, a, 32'h0);
    expect_req(0, 1'b1, 1'b0, a, 32'h0);
    set_req(1, 1'b1, 1'b0, a + 32'h400, 32'h0);
    expect_req(1, 1'b1, 1'b0, a + 32'h400, 32'h0);
    tick();
    clr_req();
    wait_free(0);
    send(0, 1'b0, 1'b1, a + 32'h800, $urandom, 1'b1);
    wait_free(1);
    send(1, 1'b0, 1'b1, a + 32'hC00, $urandom, 1'b1);
    drain();
    check("t3_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("t3_grant%0d", i), grant_log[i], exp_order[i]);

    // Test 4: strobe while busy and illegal op strobes are dropped
    resp_delay = $urandom_range(1, 4);
    send(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    send(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    send(1, 1'b0, 1'b0, 32'h60, 32'h1, 1'b0);
    check("t4_m1_none", m1_busy, 0);
    send(1, 1'b1, 1'b1, 32'h64, 32'h2, 1'b0);
    check("t4_m1_both", m1_busy, 0);
    drain();

    // Test 5: reset during WAIT, late response ignored, then normal service
    periph_en = 1'b0;
    send(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
    tick(); tick(); tick();
    check("t5_in_wait", m0_busy, 1);
    do_reset();
    inject = 1'b1;
    repeat (4) tick();
    check("t5_idle_busy", {m0_busy, m1_busy}, 2'b00);
    periph_en = 1'b1;
    send(1, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
    drain();

`ifdef W0RM_PERIPH_TIMEOUT_EN
    // Test 6: silent peripheral, M1 gets zero data and a timeout pulse
    periph_en = 1'b0;
    expect_to = 1'b1;
    send(1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1);
    exp1_q.push_back(32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge mem_clk);
      check($sformatf("t6_vout_c%0d", c), m1_valid_out, (c == TO + 3));
      tick();
    end
    expect_to = 1'b0;
    periph_en = 1'b1;
    drain();
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
